trivium_byte_io: RTL

Byte-wide front/back end for the `trivium` keystream core. Accepts the 80-bit key and 80-bit IV as a stream of 20 bytes over a valid/ready input port. It then drives the core's load and enable controls and discards the warm-up bits. After that it packs the core's serial `keystream_bit` output into bytes on a valid/ready output port. It sits between the 8-bit top-level pins and the core and removes the need for wide test-only key/IV ports.

---
 rtl/trivium_byte_io.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/trivium_byte_io.sv
// Byte-wide key/IV loader and keystream byte packer for a serial Trivium core.
// Takes 20 key/IV bytes, pulses the core load, discards the warm-up bits, then packs keystream bits LSB-first.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | accepting key/IV bytes 0..19, in_ready high
// INIT  | one-cycle core_load pulse, warm-up counter preset
// WARM  | core stepped every cycle, keystream discarded
// RUN   | keystream bits packed into bytes, output valid/ready handshake
module trivium_byte_io #(
    parameter int WARMUP = 1152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [79:0] key_out,
    output logic [79:0] iv_out,
    output logic        core_load,
    output logic        core_en,
    input  logic        core_ks,
    output logic [7:0]  ks_byte,
    output logic        ks_valid,
    input  logic        ks_ready
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_INIT,
        ST_WARM,
        ST_RUN
    } state_t;

    localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);

    state_t      state_q, state_d;
    logic [4:0]  n_q, n_d;
    logic [79:0] key_q, key_d;
    logic [79:0] iv_q, iv_d;
    logic        load_q, load_d;
    logic [15:0] warm_q, warm_d;
    logic [6:0]  pack_q, pack_d;
    logic [2:0]  pcnt_q, pcnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        accept;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        key_d    = key_q;
        iv_d     = iv_q;
        load_d   = 1'b0;
        warm_d   = warm_q;
        pack_d   = pack_q;
        pcnt_d   = pcnt_q;
        byte_d   = byte_q;
        valid_d  = valid_q;
        in_ready = (state_q == ST_LOAD);
        core_en  = 1'b0;
        accept   = in_ready & in_valid;

        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    for (int i = 0; i < 10; i++) begin
                        if (n_q == 5'(i)) key_d[8*i +: 8] = in_data;
                        if (n_q == 5'(i + 10)) iv_d[8*i +: 8] = in_data;
                    end
                    if (n_q == 5'd19) begin
                        state_d = ST_INIT;
                        load_d  = 1'b1;
                        n_d     = 5'd0;
                    end else begin
                        n_d = n_q + 5'd1;
                    end
                end
            end
            ST_INIT: begin
                state_d = ST_WARM;
                warm_d  = WARM_LAST;
            end
            ST_WARM: begin
                core_en = 1'b1;
                if (warm_q == 16'd0) begin
                    state_d = ST_RUN;
                end else begin
                    warm_d = warm_q - 16'd1;
                end
            end
            ST_RUN: begin
                // Stall only when the 8th bit would have nowhere to go.
                core_en = !((pcnt_q == 3'd7) && valid_q && !ks_ready);
                if (valid_q && ks_ready) valid_d = 1'b0;
                if (core_en) begin
                    if (pcnt_q == 3'd7) begin
                        byte_d  = {core_ks, pack_q};
                        valid_d = 1'b1;
                        pcnt_d  = 3'd0;
                    end else begin
                        pack_d = {core_ks, pack_q[6:1]};
                        pcnt_d = pcnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase

        if (restart) begin
            state_d = ST_LOAD;
            n_d     = 5'd0;
            key_d   = 80'd0;
            iv_d    = 80'd0;
            load_d  = 1'b0;
            warm_d  = 16'd0;
            pack_d  = 7'd0;
            pcnt_d  = 3'd0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            n_q     <= 5'd0;
            key_q   <= 80'd0;
            iv_q    <= 80'd0;
            load_q  <= 1'b0;
            warm_q  <= 16'd0;
            pack_q  <= 7'd0;
            pcnt_q  <= 3'd0;
            byte_q  <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            key_q   <= key_d;
            iv_q    <= iv_d;
            load_q  <= load_d;
            warm_q  <= warm_d;
            pack_q  <= pack_d;
            pcnt_q  <= pcnt_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
        end
    end

    assign key_out   = key_q;
    assign iv_out    = iv_q;
    assign core_load = load_q;
    assign ks_byte   = byte_q;
    assign ks_valid  = valid_q;

endmodule
